alu_mdu_seq: RTL and testbench

Multi-cycle successor to the single-cycle CPU ALU. It keeps the base integer operation set and adds RV32M-style multiply, divide and remainder. Multiply uses an iterative shift-add datapath; divide uses restoring division. Operands enter and results leave through valid/ready handshakes, so the core can stall on long operations. It sits in the execute stage between operand muxing and writeback.

---
 rtl/alu_mdu_seq_if.sv | 25 ++
 rtl/alu_mdu_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_mdu_seq.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mdu_seq_if.sv
// Operand/result handshake bundle between the operand muxes, the sequential
// ALU/MDU and writeback.
interface alu_mdu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_mdu_seq.sv
// Multi-cycle execute-stage ALU: single-cycle base integer ops plus iterative
// RV32M multiply (shift-add) and divide (restoring) behind valid/ready handshakes.
module alu_mdu_seq #(
  parameter int WIDTH = 32,
  parameter bit MD_EN = 1'b1
) (
  input logic          clk,
  input logic          reset,
  alu_mdu_seq_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2:0]         f3_q, f3_d;
  logic               neg_q, neg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               accept_s, is_m_s;
  logic               sign_a_s, sign_b_s, neg_a_s, neg_b_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [WIDTH:0]     mul_sum_s, div_trial_s;
  logic [2*WIDTH-1:0] mul_step_s, div_step_s, iter_s;

  function automatic logic [WIDTH-1:0] base_op(input logic [3:0] code,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [SHAMT_W-1:0] sh;
    logic [WIDTH-1:0]   r;
    sh = y[SHAMT_W-1:0];
    case (code)
      4'd0:    r = x + y;
      4'd1:    r = x - y;
      4'd2:    r = x & y;
      4'd3:    r = x | y;
      4'd4:    r = x ^ y;
      4'd5:    r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      4'd6:    r = x << sh;
      4'd7:    r = {{(WIDTH-1){1'b0}}, (x < y)};
      4'd8:    r = $unsigned($signed(x) >>> sh);
      4'd9:    r = x >> sh;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // p holds |a|*|b| for multiplies, {remainder, quotient} magnitudes for divides
  function automatic logic [WIDTH-1:0] finalize(input logic [2:0] f3,
                                                input logic neg,
                                                input logic dz,
                                                input logic [2*WIDTH-1:0] p);
    logic [2*WIDTH-1:0] sp;
    logic [WIDTH-1:0]   q, rm, r;
    sp = neg ? -p : p;
    q  = neg ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    rm = neg ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    case (f3)
      3'd0:          r = sp[WIDTH-1:0];
      3'd1,
      3'd2,
      3'd3:          r = sp[2*WIDTH-1:WIDTH];
      3'd4,
      3'd5:          r = dz ? {WIDTH{1'b1}} : q;
      default:       r = rm;
    endcase
    return r;
  endfunction

  assign accept_s = bus.in_valid & in_ready_q;
  assign is_m_s   = bus.op[4];

  // Divides: DIV/REM signed, DIVU/REMU not. Multiplies: only MULHU treats a as
  // unsigned, MULHSU/MULHU treat b as unsigned.
  assign sign_a_s = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
  assign sign_b_s = bus.op[2] ? ~bus.op[0] : ~bus.op[1];
  assign neg_a_s  = sign_a_s & bus.a[WIDTH-1];
  assign neg_b_s  = sign_b_s & bus.b[WIDTH-1];
  assign mag_a_s  = neg_a_s ? -bus.a : bus.a;
  assign mag_b_s  = neg_b_s ? -bus.b : bus.b;

  assign mul_sum_s   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                       (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign mul_step_s  = {mul_sum_s, prod_q[WIDTH-1:1]};
  assign div_trial_s = prod_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q};
  assign div_step_s  = div_trial_s[WIDTH] ? {prod_q[2*WIDTH-2:0], 1'b0}
                                          : {div_trial_s[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
  assign iter_s      = f3_q[2] ? div_step_s : mul_step_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = (is_m_s && MD_EN) ? S_CALC : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, registered from the next state
  always_comb begin
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // Datapath next-state: operand capture, one iteration per CALC cycle, result load
  always_comb begin
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && is_m_s && MD_EN) begin
          f3_d  = bus.op[2:0];
          cnt_d = CNT_W'(WIDTH);
          dz_d  = (bus.b == {WIDTH{1'b0}});
          if (bus.op[2]) begin
            mcand_d = mag_b_s;
            prod_d  = {{WIDTH{1'b0}}, mag_a_s};
            neg_d   = bus.op[1] ? neg_a_s : (neg_a_s ^ neg_b_s);
          end else begin
            mcand_d = mag_a_s;
            prod_d  = {{WIDTH{1'b0}}, mag_b_s};
            neg_d   = neg_a_s ^ neg_b_s;
          end
        end else if (accept_s) begin
          result_d = is_m_s ? {WIDTH{1'b0}} : base_op(bus.op[3:0], bus.a, bus.b);
          zero_d   = (result_d == {WIDTH{1'b0}});
        end else begin
          result_d = result_q;
        end
      end
      S_CALC: begin
        prod_d = iter_s;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = finalize(f3_q, neg_q, dz_q, iter_s);
          zero_d   = (result_d == {WIDTH{1'b0}});
        end else begin
          result_d = result_q;
        end
      end
      default: result_d = result_q;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= {CNT_W{1'b0}};
      prod_q      <= {(2*WIDTH){1'b0}};
      mcand_q     <= {WIDTH{1'b0}};
      f3_q        <= 3'd0;
      neg_q       <= 1'b0;
      dz_q        <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      zero_q      <= 1'b1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      f3_q        <= f3_d;
      neg_q       <= neg_d;
      dz_q        <= dz_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Self-checking bench for alu_mdu_seq: directed plan cases, backpressure, reset
// abort and randomized ops against an arithmetic reference model.
module tb_alu_mdu_seq;
  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_SRA    = 5'b01000;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   rst_edge = 0;
  int   rdy_mode = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t expq[$];

  alu_mdu_seq_if #(.WIDTH(32)) bus ();

  alu_mdu_seq #(.WIDTH(32), .MD_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) rst_edge <= cyc + 1;
  end

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic signed [63:0] wa, wb;
    logic [63:0]        p;
    logic [31:0]        r;
    sa = a;
    sb = b;
    wa = sa;
    wb = sb;
    p  = 64'd0;
    r  = 32'd0;
    if (op[4] == 1'b0) begin
      case (op[3:0])
        4'd0:    r = a + b;
        4'd1:    r = a - b;
        4'd2:    r = a & b;
        4'd3:    r = a | b;
        4'd4:    r = a ^ b;
        4'd5:    r = (sa < sb) ? 32'd1 : 32'd0;
        4'd6:    r = a << b[4:0];
        4'd7:    r = (a < b) ? 32'd1 : 32'd0;
        4'd8:    r = sa >>> b[4:0];
        4'd9:    r = a >> b[4:0];
        default: r = 32'd0;
      endcase
    end else begin
      case (op[2:0])
        3'd0: begin p = wa * wb; r = p[31:0]; end
        3'd1: begin p = wa * wb; r = p[63:32]; end
        3'd2: begin wb = {32'd0, b}; p = wa * wb; r = p[63:32]; end
        3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
        3'd4: begin
          if (b == 32'd0) r = 32'hFFFF_FFFF;
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
          else r = sa / sb;
        end
        3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
        3'd6: begin
          if (b == 32'd0) r = a;
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
          else r = sa % sb;
        end
        default: r = (b == 32'd0) ? a : a % b;
      endcase
    end
    return r;
  endfunction

  // Expected outputs each cycle: out_valid exactly when the pending op's latency is reached
  always @(negedge clk) begin : cmp
    logic exp_ov;
    exp_ov = 1'b0;
    if (cyc == 0) begin
    end else if (cyc == rst_edge) begin
      check("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset_result", bus.result, 32'd0);
      check("reset_zero", {31'd0, bus.zero}, 32'd1);
    end else if (reset) begin
    end else begin
      if (expq.size() != 0) exp_ov = ((cyc - expq[0].acc + 1) >= expq[0].lat);
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, (expq.size() == 0)});
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
      if (exp_ov && bus.out_valid) begin
        check("result", bus.result, expq[0].res);
        check("zero", {31'd0, bus.zero}, {31'd0, (expq[0].res == 32'd0)});
        if (bus.out_ready) void'(expq.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge
  task automatic issue(input logic [4:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                       input logic [31:0] exp_v);
    int   n;
    exp_t e;
    n = 0;
    bus.in_valid = 1'b1;
    bus.op = op_v;
    bus.a = a_v;
    bus.b = b_v;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_wait", {31'd0, (n < 200)}, 32'd1);
    @(posedge clk); #1;
    e.res = exp_v;
    e.lat = op_v[4] ? 33 : 1;
    e.acc = cyc;
    expq.push_back(e);
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.op = 5'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_wait", {31'd0, (expq.size() == 0)}, 32'd1);
    expq.delete();
  endtask

  task automatic directed(input string name, input logic [4:0] op_v, input logic [31:0] a_v,
                          input logic [31:0] b_v, input logic [31:0] exp_v);
    check({"model_", name}, model(op_v, a_v, b_v), exp_v);
    issue(op_v, a_v, b_v, exp_v);
    wait_done();
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  op_v;
    logic [31:0] a_v, b_v;
    int          n;
    bus.in_valid = 1'b0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    bus.op = 5'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    directed("add", OP_ADD, 32'd5, 32'd7, 32'd12);
    directed("sub", OP_SUB, 32'd7, 32'd7, 32'd0);
    directed("sra", OP_SRA, 32'h8000_0000, 32'd33, 32'hC000_0000);
    directed("mul", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    directed("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    directed("mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    directed("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    directed("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    directed("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    directed("divu", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
    directed("divu_by0", OP_DIVU, 32'd10, 32'd0, 32'hFFFF_FFFF);
    directed("remu_by0", OP_REMU, 32'd10, 32'd0, 32'd10);
    directed("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    directed("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    directed("div_by0_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);

    // Backpressure: result held while stalled, busy-time in_valid ignored
    rdy_mode = 2;
    issue(OP_MUL, 32'd6, 32'd7, 32'd42);
    n = 0;
    while (!bus.out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_out_valid_wait", {31'd0, (n < 60)}, 32'd1);
    bus.in_valid = 1'b1;
    bus.op = OP_ADD;
    bus.a = 32'd1;
    bus.b = 32'd1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rdy_mode = 0;
    wait_done();
    directed("after_bp", OP_ADD, 32'd100, 32'd23, 32'd123);

    // Reset ten cycles into a divide: the divide must never complete
    issue(OP_DIV, 32'd1000, 32'd7, model(OP_DIV, 32'd1000, 32'd7));
    repeat (10) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    expq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    directed("after_reset", OP_ADD, 32'd3, 32'd4, 32'd7);

    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(2) == 0) op_v = {1'b0, 4'($urandom)};
      else op_v = {1'b1, 1'($urandom), 3'($urandom)};
      a_v = pick_operand();
      b_v = pick_operand();
      repeat ($urandom_range(2)) begin
        @(posedge clk); #1;
      end
      issue(op_v, a_v, b_v, model(op_v, a_v, b_v));
    end
    wait_done();
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
